// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: samples up to NIRQ source lines, latches them
// into PEND per level/edge MODE, masks with EN and reports the lowest active index.
module irq_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NIRQ  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             wen,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic [NIRQ-1:0]  irqs,
    output logic             irq,
    output logic [4:0]       irq_id
);

    localparam int unsigned ID_W = 5;

    localparam logic [2:0] A_PEND   = 3'd0;
    localparam logic [2:0] A_EN     = 3'd1;
    localparam logic [2:0] A_MODE   = 3'd2;
    localparam logic [2:0] A_ACTIVE = 3'd3;
    localparam logic [2:0] A_RAW    = 3'd4;
    localparam logic [2:0] A_SET    = 3'd5;

    logic [NIRQ-1:0] s, p, pend, en, mode;
    logic [NIRQ-1:0] edge_v, setv, clrv, ack_v, w1c_v, swset_v, act;
    logic [ID_W-1:0] act_id;
    logic            wr;

    assign wr = cs & wen;

    // Bus-driven set/clear terms; the ACK uses the registered irq/irq_id of this cycle.
    assign w1c_v   = (wr && addr == A_PEND) ? din[NIRQ-1:0] : '0;
    assign swset_v = (wr && addr == A_SET)  ? din[NIRQ-1:0] : '0;
    assign ack_v   = (wr && addr == A_ACTIVE && irq) ? (NIRQ'(1) << irq_id) : '0;

    assign edge_v = s & ~p;
    assign setv   = (mode & edge_v) | (~mode & s) | swset_v;
    assign clrv   = w1c_v | ack_v;
    assign act    = pend & en;

    // Fixed priority: lowest index wins, so scan downward and let lower bits overwrite.
    always_comb begin
        act_id = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (act[i]) act_id = ID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s      <= '0;
            p      <= '0;
            pend   <= '0;
            en     <= '0;
            mode   <= '0;
            irq    <= 1'b0;
            irq_id <= '0;
        end else begin
            s      <= irqs;
            p      <= s;
            // Set beats clear, so a still-asserted level source re-pends at once.
            pend   <= (pend & ~clrv) | setv;
            if (wr && addr == A_EN)   en   <= din[NIRQ-1:0];
            if (wr && addr == A_MODE) mode <= din[NIRQ-1:0];
            irq    <= |act;
            irq_id <= act_id;
        end
    end

    // Read mux; unmapped and write-only addresses read zero.
    always_comb begin
        dout = '0;
        case (addr)
            A_PEND:   dout = WIDTH'(pend);
            A_EN:     dout = WIDTH'(en);
            A_MODE:   dout = WIDTH'(mode);
            A_ACTIVE: begin
                dout[WIDTH-1]  = irq;
                dout[ID_W-1:0] = irq_id;
            end
            A_RAW:    dout = WIDTH'(s);
            default:  dout = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expected values are queued as each step is driven
// and popped when the corresponding DUT output is sampled.
module tb_irq_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NIRQ  = 32;

    logic             clk;
    logic             reset;
    logic             cs;
    logic             wen;
    logic [2:0]       addr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [NIRQ-1:0]  irqs;
    logic             irq;
    logic [4:0]       irq_id;

    irq_ctrl #(.WIDTH(WIDTH), .NIRQ(NIRQ)) dut (
        .clk    (clk),
        .reset  (reset),
        .cs     (cs),
        .wen    (wen),
        .addr   (addr),
        .din    (din),
        .dout   (dout),
        .irqs   (irqs),
        .irq    (irq),
        .irq_id (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h required=entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wen = 1'b1; addr = a; din = d;
        tick();
        cs = 1'b0; wen = 1'b0; din = '0;
    endtask

    task automatic rd(input logic [2:0] a, input string tag, input logic [31:0] expv);
        push_exp(tag, expv);
        cs = 1'b1; wen = 1'b0; addr = a;
        #1;
        pop_chk(dout);
        cs = 1'b0;
    endtask

    task automatic chk_irq(input string tag, input logic e_irq, input logic [4:0] e_id);
        push_exp({tag, "_irq"}, 32'(e_irq));
        push_exp({tag, "_id"}, 32'(e_id));
        #1;
        pop_chk(32'(irq));
        pop_chk(32'(irq_id));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; cs = 1'b0; wen = 1'b0; addr = '0; din = '0; irqs = '0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        tick();

        // Reset state
        rd(3'd0, "rst_pend", 32'h0);
        rd(3'd1, "rst_en", 32'h0);
        rd(3'd2, "rst_mode", 32'h0);
        rd(3'd3, "rst_active", 32'h0);
        rd(3'd4, "rst_raw", 32'h0);
        chk_irq("rst", 1'b0, 5'd0);

        // Writes with cs=0 and to unmapped addresses are ignored
        cs = 1'b0; wen = 1'b1; addr = 3'd1; din = 32'hFF;
        tick();
        wen = 1'b0;
        rd(3'd1, "cs0_write", 32'h0);
        wr(3'd6, 32'hFF);
        rd(3'd6, "unmapped_rd", 32'h0);
        rd(3'd0, "unmapped_pend", 32'h0);
        rd(3'd5, "set_rd", 32'h0);

        // Level source 0: latency and W1C while still high
        wr(3'd1, 32'h1);
        irqs[0] = 1'b1;
        tick();                                   // s=1
        rd(3'd4, "lvl_raw", 32'h1);
        rd(3'd0, "lvl_pend_n", 32'h0);
        tick();                                   // PEND=1
        rd(3'd0, "lvl_pend_n1", 32'h1);
        chk_irq("lvl_n1", 1'b0, 5'd0);
        tick();                                   // irq=1
        chk_irq("lvl_n2", 1'b1, 5'd0);
        rd(3'd3, "lvl_active", 32'h8000_0000);
        wr(3'd0, 32'h1);
        rd(3'd0, "lvl_w1c_held", 32'h1);
        irqs[0] = 1'b0;
        tick();                                   // s=0
        wr(3'd0, 32'h1);
        rd(3'd0, "lvl_w1c_low", 32'h0);
        tick();
        chk_irq("lvl_drop", 1'b0, 5'd0);

        // Edge source 2: held high pends once, ACK clears for good
        wr(3'd1, 32'h4);
        wr(3'd2, 32'h4);
        rd(3'd2, "mode_rd", 32'h4);
        irqs[2] = 1'b1;
        repeat (10) tick();
        rd(3'd0, "edge_pend", 32'h4);
        chk_irq("edge_held", 1'b1, 5'd2);
        wr(3'd3, 32'h0);
        rd(3'd0, "edge_ack", 32'h0);
        tick();
        chk_irq("edge_ack", 1'b0, 5'd0);
        repeat (3) tick();
        rd(3'd0, "edge_still_held", 32'h0);
        irqs[2] = 1'b0;
        tick();
        tick();
        irqs[2] = 1'b1;                           // one-cycle pulse
        tick();
        irqs[2] = 1'b0;
        tick();
        rd(3'd0, "edge_pulse", 32'h4);
        tick();
        chk_irq("edge_pulse", 1'b1, 5'd2);
        wr(3'd3, 32'h0);
        tick();
        rd(3'd0, "edge_clean", 32'h0);

        // Software set and priority walk via ACK
        wr(3'd1, 32'hFFFF_FFFF);
        rd(3'd1, "en_all", 32'hFFFF_FFFF);
        wr(3'd5, 32'h0000_0028);
        rd(3'd0, "sw_pend", 32'h28);
        tick();
        chk_irq("prio_3", 1'b1, 5'd3);
        wr(3'd3, 32'h0);
        tick();
        chk_irq("prio_5", 1'b1, 5'd5);
        rd(3'd3, "active_5", 32'h8000_0005);
        wr(3'd3, 32'h0);
        tick();
        chk_irq("prio_none", 1'b0, 5'd0);
        rd(3'd0, "prio_pend", 32'h0);

        // Enable gating retains PEND
        wr(3'd1, 32'h0);
        wr(3'd5, 32'h80);
        tick();
        tick();
        chk_irq("masked", 1'b0, 5'd0);
        rd(3'd0, "masked_pend", 32'h80);
        wr(3'd1, 32'h80);
        tick();
        chk_irq("unmasked", 1'b1, 5'd7);
        wr(3'd1, 32'h0);
        tick();
        chk_irq("remasked", 1'b0, 5'd0);
        rd(3'd0, "remasked_pend", 32'h80);
        wr(3'd0, 32'h80);

        // Edge set and W1C in the same cycle: set wins
        wr(3'd2, 32'h6);
        wr(3'd5, 32'h2);
        irqs[1] = 1'b1;
        tick();                                   // s[1]=1, edge term live
        wr(3'd0, 32'h2);
        rd(3'd0, "set_wins", 32'h2);
        rd(3'd2, "mode_keeps_pend", 32'h6);

        // Asynchronous reset mid-stream
        wr(3'd1, 32'h2);
        tick();
        chk_irq("pre_reset", 1'b1, 5'd1);
        #2 reset = 1'b0;
        addr = 3'd0;
        chk_irq("async_reset", 1'b0, 5'd0);
        rd(3'd0, "async_pend", 32'h0);
        rd(3'd1, "async_en", 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        rd(3'd4, "post_raw", 32'h2);
        rd(3'd0, "post_pend", 32'h0);
        irqs = '0;

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
